// File: rtl/inv_sub_bytes_seq_if.sv
// Handshake bundle for inv_sub_bytes_seq: 128-bit state in, 128-bit state out,
// both on valid/ready. The slave modport is the engine side.
interface inv_sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: LANES shared inverse S-box lookups per
// clock over a 128-bit working register, NCYC = 16/LANES cycles per state.
// Optional macro INV_SUB_BYTES_FWD_MODE_EN adds a fwd input that selects the
// forward S-box for the whole operation (sampled on the accepting edge).
//
// state | meaning
// IDLE  | in_ready high, waiting for a state to accept
// RUN   | substituting LANES bytes per edge, group index in cnt_q
// DONE  | out_valid high, out_data stable until out_ready
module inv_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_sub_bytes_seq_if.slave   bus,
    output logic                 busy
`ifdef INV_SUB_BYTES_FWD_MODE_EN
    ,
    input  logic                 fwd
`endif
);
    localparam int NCYC = 16 / LANES;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [127:0]  work_q;
    logic [127:0]  work_d;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
    logic          fwd_q;
`endif

    // Rows of the FIPS-197 InvSbox, selected by high nibble; column by low nibble.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [127:0] row;
        row = '0;
        case (b[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction

`ifdef INV_SUB_BYTES_FWD_MODE_EN
    // Rows of the FIPS-197 forward Sbox, same layout as inv_sbox.
    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        logic [127:0] row;
        row = '0;
        case (b[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[{~b[3:0], 3'b000} +: 8];
    endfunction
`endif

    function automatic logic [7:0] lane_sub(input logic [7:0] b, input logic use_fwd);
`ifdef INV_SUB_BYTES_FWD_MODE_EN
        return use_fwd ? fwd_sbox(b) : inv_sbox(b);
`else
        logic unused_fwd;
        unused_fwd = use_fwd;
        return inv_sbox(b);
`endif
    endfunction

    // Current byte group replaced by its substitution; other bytes pass through.
    always_comb begin
        logic sel_fwd;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
        sel_fwd = fwd_q;
`else
        sel_fwd = 1'b0;
`endif
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[(32'(cnt_q) * LANES + l) * 8 +: 8] =
                lane_sub(work_q[(32'(cnt_q) * LANES + l) * 8 +: 8], sel_fwd);
        end
    end

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
            fwd_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q     <= bus.in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
`ifdef INV_SUB_BYTES_FWD_MODE_EN
                        fwd_q      <= fwd;
`endif
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    // With a single group the counter stays tied at zero.
                    if (NCYC > 1) cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work_q;
    assign busy          = busy_q;
endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Iterative AES InvSubBytes engine for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and applies the FIPS-197 inverse S-box to LANES bytes per clock. It presents the substituted state on a valid/ready output. Sharing LANES inverse S-box instances keeps area below the 16-instance combinational form.

Parameters:
LANES, 4, bytes substituted per RUN cycle; legal values 1, 2, 4, 8, 16 (must divide 16).
NCYC, 16/LANES, derived localparam, number of RUN cycles; not user-overridable.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a state
in_data  input  128  ciphertext-side state; byte i = bits [8i+7:8i]
out_valid  output  1  out_data holds a completed result
out_ready  input  1  downstream accepts out_data
out_data  output  128  InvSubBytes(in_data), same byte mapping
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low. All state registers clear immediately on rst_n low.
- Reset values: state = IDLE, byte counter = 0, working register = 0. Outputs: out_data = 0, out_valid = 0, in_ready = 1, busy = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On an edge with in_valid & in_ready: latch in_data into the working register, clear the counter, go to RUN.
- RUN: in_ready = 0. Each edge replaces bytes [cnt*LANES, cnt*LANES+LANES-1] with InvSbox(byte), then cnt += 1.
- RUN exit: on the edge where cnt == NCYC-1 (the last group is written), go to DONE. The counter width is clog2(NCYC), minimum 1, and wraps to 0.
- DONE: out_valid = 1 and out_data is stable. On an edge with out_ready, go to IDLE; out_valid drops the following cycle. Without out_ready, hold indefinitely.
- Latency: out_valid rises exactly NCYC clocks after the accepting edge (4 for LANES=4).
- Throughput: one state per NCYC+2 clocks. in_ready is low in DONE, so no accept can overlap with output.
- out_data is driven directly from the working register. Its value is defined only while out_valid = 1; partial results are visible during RUN and must not be consumed.
- in_valid in RUN/DONE is ignored. in_data changes after acceptance have no effect.
- out_ready while not in DONE is ignored.
- LANES=16: a single RUN cycle; the counter is unused (tie to 0).
- Reset mid-operation (rst_n low in RUN or DONE): the operation aborts, no out_valid pulse is produced, and the block returns to IDLE.
- Inverse S-box: a 256-entry constant table per FIPS-197 (InvSbox[0x63]=0x00, [0x00]=0x52, [0xFF]=0x7D). It is implemented as a synthesizable case ROM, not a file load, so it synthesizes without a hex file.

Optional Feature:
Macro INV_SUB_BYTES_FWD_MODE_EN.
- Defined: adds input port fwd (1 bit), sampled on the accepting edge and held for the whole operation. fwd = 1 applies the forward S-box (S[0x00]=0x63, S[0x53]=0xED); fwd = 0 applies the inverse S-box. One block then serves both encrypt and decrypt paths.
- Not defined: no fwd port, no forward table; the block is inverse-only.

Test Plan:
1. Reset then idle: rst_n low for 3 clocks, release -> in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
2. All 0x63 input, LANES=4, out_ready = 1 -> out_valid high exactly 4 clocks after accept, out_data = 128'h0, returns to IDLE next cycle.
3. Byte ordering: in_data = 128'h0000_0000_0000_0000_0000_0000_0000_7C63 -> out_data = 128'h5252_5252_5252_5252_5252_5252_5252_0100.
4. Backpressure: hold out_ready = 0 for 10 clocks in DONE, toggling in_valid with new data -> out_data stable, in_ready = 0, no second accept. Raise out_ready -> one transfer, then accept the pending in_valid in IDLE.
5. Abort: assert rst_n low on the 2nd RUN cycle -> out_valid never asserts, IDLE resumes. A following accept of all-0xFF -> out_data = all 0x7D.
6. Round trip and sweep: random 128-bit X through the forward SubBytes block, then this block for LANES = 1, 4, 16 -> out_data == X, latencies 16, 4, 1. With INV_SUB_BYTES_FWD_MODE_EN and fwd = 1, input all 0x53 -> out_data all 0xED.
